// File: rtl/io_uart_tx.sv
// io_uart_tx: buffers core character writes in a FIFO and serialises them as 8N1 on uart_txd; never stalls the core, drops and flags on overflow.
// Optional IO_UART_FINISH_DUMP_EN: a finish pulse enqueues "=XXXX\r\n" carrying the result in hex.
module io_uart_tx #(
  parameter int          CLK_HZ     = 50000000,
  parameter int          BAUD       = 115200,
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [12:0] UART_ADDR  = 13'h0000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  iowrite,
  input  logic [12:0]           ioaddr,
  input  logic [12:0]           iowd,
  input  logic                  finish,
  input  logic [15:0]           result,
  input  logic                  overflow_clr,
  output logic                  uart_txd,
  output logic                  tx_busy,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow
);

  localparam int                  DIV       = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam int                  BW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0]       BAUD_LAST = BW'(DIV - 1);
  localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                r_state, w_state_nxt;
  logic [BW-1:0]         r_baud, w_baud_nxt;
  logic [2:0]            r_bit, w_bit_nxt;
  logic [7:0]            r_shift, w_shift_nxt;
  logic                  r_txd;
  logic                  r_tx_busy;
  logic                  r_overflow;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_level;

  logic                  w_io_push;
  logic                  w_push_vld;
  logic [7:0]            w_push_dat;
  logic                  w_full, w_empty;
  logic                  w_pop, w_wr, w_drop;
  logic                  w_baud_end;
  logic                  w_unused;

  assign w_io_push  = iowrite && (ioaddr == UART_ADDR);
  assign w_full     = (r_level == LVL_FULL);
  assign w_empty    = (r_level == '0);
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  // A pop frees the slot in the same cycle, so a push at full is still accepted.
  assign w_wr       = w_push_vld && (!w_full || w_pop);
  assign w_drop     = w_io_push && w_full && !w_pop;
  assign w_baud_end = (r_baud == BAUD_LAST);

`ifdef IO_UART_FINISH_DUMP_EN
  logic        r_finish_d;
  logic        r_dump_act;
  logic [2:0]  r_dump_idx;
  logic [15:0] r_dump_val;
  logic        w_dump_push;
  logic [7:0]  w_dump_dat;
  logic [3:0]  w_nib;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    w_nib      = r_dump_val[15:12];
    w_dump_dat = 8'h0A;
    case (r_dump_idx)
      3'd0: w_dump_dat = 8'h3D;
      3'd1: begin w_nib = r_dump_val[15:12]; w_dump_dat = hex_char(w_nib); end
      3'd2: begin w_nib = r_dump_val[11:8];  w_dump_dat = hex_char(w_nib); end
      3'd3: begin w_nib = r_dump_val[7:4];   w_dump_dat = hex_char(w_nib); end
      3'd4: begin w_nib = r_dump_val[3:0];   w_dump_dat = hex_char(w_nib); end
      3'd5: w_dump_dat = 8'h0D;
      default: w_dump_dat = 8'h0A;
    endcase
  end

  // Core writes win the FIFO port; the dump simply retries next cycle.
  assign w_dump_push = r_dump_act && !w_io_push && !w_full;
  assign w_push_vld  = w_io_push || w_dump_push;
  assign w_push_dat  = w_io_push ? iowd[7:0] : w_dump_dat;
  assign w_unused    = ^iowd[12:8];

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_finish_d <= 1'b0;
      r_dump_act <= 1'b0;
      r_dump_idx <= '0;
      r_dump_val <= '0;
    end else begin
      r_finish_d <= finish;
      if (!r_dump_act) begin
        if (finish && !r_finish_d) begin
          r_dump_act <= 1'b1;
          r_dump_idx <= '0;
          r_dump_val <= result;
        end
      end else if (w_dump_push) begin
        if (r_dump_idx == 3'd6) r_dump_act <= 1'b0;
        r_dump_idx <= r_dump_idx + 3'd1;
      end
    end
  end
`else
  assign w_push_vld = w_io_push;
  assign w_push_dat = iowd[7:0];
  assign w_unused   = ^{finish, result, iowd[12:8]};
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_wr) r_mem[r_wptr] <= w_push_dat;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = S_START;
          w_baud_nxt  = '0;
          w_shift_nxt = r_mem[r_rptr];
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_state_nxt = S_IDLE;
          w_baud_nxt  = '0;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line and busy are registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_tx_busy <= (r_state != S_IDLE) || !w_empty;
      case (r_state)
        S_START: r_txd <= 1'b0;
        S_DATA:  r_txd <= r_shift[0];
        default: r_txd <= 1'b1;
      endcase
      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  assign uart_txd   = r_txd;
  assign tx_busy    = r_tx_busy;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: a line monitor decodes every frame and checks it cycle-exactly against a queue of expected bytes.
module tb_io_uart_tx;

  localparam int          DIV   = 16;
  localparam logic [12:0] UADDR = 13'h0000;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n, iowrite, finish, overflow_clr;
  logic [12:0] ioaddr, iowd;
  logic [15:0] result;
  logic        uart_txd, tx_busy, overflow;
  logic [4:0]  fifo_level;

  int          n_err = 0;
  int          n_checks = 0;
  int          cyc = 0;
  int          frames_done = 0;
  bit          abort_flag = 1'b0;
  logic [7:0]  exp_q[$];
  int          start_q[$];

  io_uart_tx #(
    .CLK_HZ(50000000), .BAUD(3125000), .DEPTH_LOG2(4), .UART_ADDR(UADDR)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .iowrite(iowrite), .ioaddr(ioaddr),
    .iowd(iowd), .finish(finish), .result(result), .overflow_clr(overflow_clr),
    .uart_txd(uart_txd), .tx_busy(tx_busy), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge CLOCK_50);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int t;
    t = 0;
    while (frames_done < target && t < budget) begin
      @(negedge CLOCK_50);
      t++;
    end
    check("frames_done_in_time", (frames_done >= target) ? 1 : 0, 1);
  endtask

  task automatic io_push(input logic [12:0] addr, input logic [12:0] data);
    iowrite = 1'b1;
    ioaddr  = addr;
    iowd    = data;
    @(negedge CLOCK_50);
    iowrite = 1'b0;
  endtask

  // Monitor: every frame is compared bit-for-bit, cycle-for-cycle, against the next expected byte.
  initial begin : monitor
    logic [7:0] b, rx;
    logic [9:0] pat;
    int         bad;
    bit         aborted;
    forever begin
      @(negedge CLOCK_50);
      if (uart_txd === 1'b0 && !abort_flag) begin
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_frame: line went low with no byte expected (cycle %0d)", cyc);
          repeat (10 * DIV - 1) @(negedge CLOCK_50);
        end else begin
          b = exp_q.pop_front();
          pat = {1'b1, b, 1'b0};
          bad = 0;
          rx = 8'h00;
          aborted = 1'b0;
          for (int k = 0; k < 10 * DIV; k++) begin
            if (k > 0) @(negedge CLOCK_50);
            if (abort_flag) begin
              aborted = 1'b1;
              break;
            end
            if (uart_txd !== pat[k / DIV]) bad++;
            if ((k % DIV) == DIV / 2 && k >= DIV && k < 9 * DIV) rx[k / DIV - 1] = uart_txd;
          end
          if (!aborted) begin
            check("frame_byte", rx, b);
            check("frame_timing_bad_cycles", bad, 0);
            frames_done++;
          end
        end
      end
    end
  end

  initial begin : stim
    int  push_cyc, p0, pop2, r_edge, fd0, bad, lat;
    logic [7:0] b;
    reset_n = 1'b0; iowrite = 1'b0; ioaddr = '0; iowd = '0;
    finish = 1'b0; result = '0; overflow_clr = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("reset_txd", uart_txd, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_level", fifo_level, 0);
    check("reset_overflow", overflow, 0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);

    // Single 0x55 frame: latency, alternating line, busy window.
    start_q.delete();
    fd0 = frames_done;
    exp_q.push_back(8'h55);
    push_cyc = cyc + 1;
    io_push(UADDR, 13'h0055);
    check("level_after_push", fifo_level, 1);
    wait_cyc(push_cyc + 5 * DIV);
    check("busy_mid_frame", tx_busy, 1);
    wait_cyc(push_cyc + 1 + 10 * DIV);
    check("busy_last_stop_cycle", tx_busy, 1);
    @(negedge CLOCK_50);
    check("busy_after_stop", tx_busy, 0);
    wait_frames(fd0 + 1, 50);
    lat = (start_q.size() > 0) ? start_q[0] - push_cyc : -1;
    check("start_latency", lat, 2);

    // Wrong address: nothing queued, line stays idle.
    io_push(13'h0001, 13'h0041);
    bad = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      if (uart_txd !== 1'b1) bad++;
      @(negedge CLOCK_50);
    end
    check("wrong_addr_line_idle", bad, 0);
    check("wrong_addr_level", fifo_level, 0);

    // 18-byte burst: 17 accepted, the last dropped; then a push exactly on a pop at full.
    start_q.delete();
    fd0 = frames_done;
    p0 = cyc + 1;
    for (int i = 0; i < 18; i++) begin
      b = 8'h30 + 8'(i);
      iowrite = 1'b1;
      ioaddr  = UADDR;
      iowd    = {5'h1F, b};
      if (i < 17) exp_q.push_back(b);
      @(negedge CLOCK_50);
      if (i == 16) check("overflow_before_drop", overflow, 0);
    end
    iowrite = 1'b0;
    check("overflow_after_drop", overflow, 1);
    check("level_full", fifo_level, 16);
    overflow_clr = 1'b1;
    @(negedge CLOCK_50);
    overflow_clr = 1'b0;
    check("overflow_cleared", overflow, 0);
    pop2 = p0 + 2 + 10 * DIV;
    wait_cyc(pop2 - 1);
    check("level_full_before_pop", fifo_level, 16);
    exp_q.push_back(8'hA5);
    io_push(UADDR, 13'h00A5);
    check("level_push_on_pop", fifo_level, 16);
    check("overflow_push_on_pop", overflow, 0);
    wait_frames(fd0 + 18, 20 * (10 * DIV + 1) + 100);
    check("burst_frame_count", start_q.size(), 18);
    bad = 0;
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] != 10 * DIV + 1) bad++;
    check("burst_gap_bad", bad, 0);
    lat = (start_q.size() > 0) ? start_q[0] - p0 : -1;
    check("burst_start_latency", lat, 2);

    // Reset during data bit 3, then a clean frame.
    fd0 = frames_done;
    exp_q.push_back(8'h35);
    push_cyc = cyc + 1;
    io_push(UADDR, 13'h0035);
    r_edge = push_cyc + 1 + 4 * DIV + DIV / 2;
    wait_cyc(r_edge - 2);
    abort_flag = 1'b1;
    @(negedge CLOCK_50);
    check("line_bit3_before_reset", uart_txd, 0);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    check("abort_txd", uart_txd, 1);
    check("abort_level", fifo_level, 0);
    check("abort_busy", tx_busy, 0);
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge CLOCK_50);
    abort_flag = 1'b0;
    exp_q.push_back(8'h5A);
    io_push(UADDR, 13'h005A);
    wait_frames(fd0 + 1, 12 * DIV);

`ifdef IO_UART_FINISH_DUMP_EN
    // Finish dump with a same-cycle core write that must go first.
    fd0 = frames_done;
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h3D);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h46);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    finish = 1'b1;
    result = 16'hBEEF;
    io_push(UADDR, 13'h0021);
    finish = 1'b0;
    result = 16'h0000;
    wait_frames(fd0 + 8, 9 * (10 * DIV + 1) + 100);
    check("dump_overflow", overflow, 0);
`endif

    repeat (3) @(negedge CLOCK_50);
    check("expected_queue_drained", exp_q.size(), 0);
    check("final_idle_busy", tx_busy, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
